// File: rtl/sw_onehot_debounce_if.sv
// Signal bundle between the raw switch inputs, the debounce stage and the encoder/LED consumers.
// Level-only links: sw_in is sampled every clock and the outputs are valid every clock; there is no valid/ready pair and no back-pressure.
interface sw_onehot_debounce_if;
  logic [3:0] sw_in;
  logic [3:0] sw_db;
  logic [3:0] sw_out;
  logic       chg;
  logic       multi;

  modport master (
    output sw_in,
    input  sw_db,
    input  sw_out,
    input  chg,
    input  multi
  );

  modport slave (
    input  sw_in,
    output sw_db,
    output sw_out,
    output chg,
    output multi
  );
endinterface

// File: rtl/sw_onehot_debounce.sv
// Four-switch synchroniser and debouncer feeding a 4-to-2 encoder with a one-hot-or-zero vector,
// plus a change strobe and a multi-switch flag for status LEDs.
module sw_onehot_debounce #(
  parameter int CNT_MAX = 240000
) (
  input  logic                 clk,
  input  logic                 rst,
  sw_onehot_debounce_if.slave  bus
);

  localparam int             CW       = $clog2(CNT_MAX);
  localparam logic [CW-1:0]  CNT_LAST = CW'(CNT_MAX - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic [3:0]          s1_q, s2_q;
  logic [3:0]          db_q, db_d;
  logic [3:0][CW-1:0]  cnt_q, cnt_d;
  logic [3:0]          sw_out_q, sw_out_d;
  logic [3:0]          sw_last_q;
  logic                chg_q, chg_d;
  logic                multi_q, multi_d;
  logic [2:0]          pop;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    popcnt4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= bus.sw_in;
      s2_q <= s1_q;
    end
  end

  // Each bit counts consecutive mismatches; any match restarts the count.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i]  = s2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q  <= '0;
      cnt_q <= '0;
    end else begin
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  // With two or more switches on the encoder keeps its last legal code.
  always_comb begin
    pop      = popcnt4(db_q);
    sw_out_d = sw_out_q;
    if (pop == 3'd0) begin
      sw_out_d = 4'b0000;
    end else if (pop == 3'd1) begin
      sw_out_d = db_q;
    end
    multi_d = (pop >= 3'd2);
    chg_d   = (sw_out_q != sw_last_q);
  end

  // sw_last_q trails sw_out_q by one cycle so chg lands the cycle after sw_out moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_out_q  <= '0;
      sw_last_q <= '0;
      chg_q     <= 1'b0;
      multi_q   <= 1'b0;
    end else begin
      sw_out_q  <= sw_out_d;
      sw_last_q <= sw_out_q;
      chg_q     <= chg_d;
      multi_q   <= multi_d;
    end
  end

  assign bus.sw_db  = db_q;
  assign bus.sw_out = sw_out_q;
  assign bus.chg    = chg_q;
  assign bus.multi  = multi_q;

endmodule

// File: tb/tb_sw_onehot_debounce.sv
// Directed bench for sw_onehot_debounce with CNT_MAX=4; inputs change and outputs are sampled 1 ns after a rising edge.
module tb_sw_onehot_debounce;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   chg_cnt;
  int   c0;

  sw_onehot_debounce_if bus ();

  sw_onehot_debounce #(.CNT_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.chg === 1'b1) chg_cnt++;
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check4(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    assert (got == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    chg_cnt    = 0;
    rst        = 1'b1;
    bus.sw_in  = 4'b0000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check4("rst_sw_db", bus.sw_db, 4'b0000);
    check4("rst_sw_out", bus.sw_out, 4'b0000);
    check4("rst_chg", {3'b000, bus.chg}, 4'b0000);
    check4("rst_multi", {3'b000, bus.multi}, 4'b0000);
    edges(4);

    // clean press
    c0 = chg_cnt;
    bus.sw_in = 4'b0001;
    edges(5);
    check4("press_db_e5", bus.sw_db, 4'b0000);
    edges(1);
    check4("press_db_e6", bus.sw_db, 4'b0001);
    check4("press_out_e6", bus.sw_out, 4'b0000);
    edges(1);
    check4("press_out_e7", bus.sw_out, 4'b0001);
    check4("press_chg_e7", {3'b000, bus.chg}, 4'b0000);
    edges(1);
    check4("press_chg_e8", {3'b000, bus.chg}, 4'b0001);
    edges(1);
    check4("press_chg_e9", {3'b000, bus.chg}, 4'b0000);
    edges(2);
    check_int("press_chg_pulses", chg_cnt - c0, 1);

    // multi: second switch on, then first released
    c0 = chg_cnt;
    bus.sw_in = 4'b0101;
    edges(6);
    check4("multi_db", bus.sw_db, 4'b0101);
    check4("multi_flag_e6", {3'b000, bus.multi}, 4'b0000);
    edges(1);
    check4("multi_flag_e7", {3'b000, bus.multi}, 4'b0001);
    check4("multi_hold_out", bus.sw_out, 4'b0001);
    edges(3);
    check_int("multi_no_chg", chg_cnt - c0, 0);
    bus.sw_in = 4'b0100;
    edges(6);
    check4("multi_rel_db", bus.sw_db, 4'b0100);
    edges(1);
    check4("multi_rel_flag", {3'b000, bus.multi}, 4'b0000);
    check4("multi_rel_out", bus.sw_out, 4'b0100);
    edges(1);
    check4("multi_rel_chg", {3'b000, bus.chg}, 4'b0001);
    edges(2);
    check_int("multi_rel_pulses", chg_cnt - c0, 1);

    // release all
    c0 = chg_cnt;
    bus.sw_in = 4'b0000;
    edges(8);
    check4("rel_out", bus.sw_out, 4'b0000);
    edges(2);
    check_int("rel_pulses", chg_cnt - c0, 1);

    // short glitch: 3 cycles high
    c0 = chg_cnt;
    bus.sw_in = 4'b0100;
    edges(3);
    bus.sw_in = 4'b0000;
    edges(10);
    check4("glitch_db", bus.sw_db, 4'b0000);
    check4("glitch_out", bus.sw_out, 4'b0000);
    check_int("glitch_pulses", chg_cnt - c0, 0);

    // bounce 1,0,1,1,1,...: count restarts after the 0
    bus.sw_in = 4'b0100;
    edges(1);
    bus.sw_in = 4'b0000;
    edges(1);
    bus.sw_in = 4'b0100;
    edges(5);
    check4("bounce_db_e5", bus.sw_db, 4'b0000);
    edges(1);
    check4("bounce_db_e6", bus.sw_db, 4'b0100);
    edges(1);
    check4("bounce_out", bus.sw_out, 4'b0100);
    edges(1);
    check4("bounce_chg", {3'b000, bus.chg}, 4'b0001);
    bus.sw_in = 4'b0000;
    edges(10);
    check4("bounce_rel_out", bus.sw_out, 4'b0000);

    // asynchronous reset mid-cycle with all switches on
    bus.sw_in = 4'b0001;
    edges(10);
    check4("pre_rst_out", bus.sw_out, 4'b0001);
    bus.sw_in = 4'b1111;
    edges(2);
    #3 rst = 1'b1;
    #1;
    check4("arst_sw_db", bus.sw_db, 4'b0000);
    check4("arst_sw_out", bus.sw_out, 4'b0000);
    check4("arst_chg", {3'b000, bus.chg}, 4'b0000);
    check4("arst_multi", {3'b000, bus.multi}, 4'b0000);
    @(posedge clk);
    #1 rst = 1'b0;
    c0 = chg_cnt;
    edges(5);
    check4("arst_db_e5", bus.sw_db, 4'b0000);
    edges(1);
    check4("arst_db_e6", bus.sw_db, 4'b1111);
    check4("arst_multi_e6", {3'b000, bus.multi}, 4'b0000);
    edges(1);
    check4("arst_multi_e7", {3'b000, bus.multi}, 4'b0001);
    check4("arst_out_e7", bus.sw_out, 4'b0000);
    edges(3);
    check_int("arst_no_chg", chg_cnt - c0, 0);

    bus.sw_in = 4'b0000;
    edges(10);
    check4("clr_db", bus.sw_db, 4'b0000);
    check4("clr_multi", {3'b000, bus.multi}, 4'b0000);

    // reset while a counter sits at 2
    bus.sw_in = 4'b0010;
    edges(4);
    rst = 1'b1;
    #2 rst = 1'b0;
    check4("midrst_db", bus.sw_db, 4'b0000);
    edges(5);
    check4("midrst_db_e5", bus.sw_db, 4'b0000);
    edges(1);
    check4("midrst_db_e6", bus.sw_db, 4'b0010);
    edges(1);
    check4("midrst_out_e7", bus.sw_out, 4'b0010);
    edges(1);
    check4("midrst_chg_e8", {3'b000, bus.chg}, 4'b0001);
    edges(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
